// File: rtl/trig_series_pkg.sv
// Shared constants, types and Q2.16 Taylor coefficient tables for the trig series engine.
// Term k of either series multiplies x^(2k+1).
package trig_series_pkg;

  localparam int COEF_FRAC = 16;
  localparam int COEF_W    = 18;
  localparam int MAX_TERMS = 8;
  localparam int K_W       = $clog2(MAX_TERMS);
  localparam int B_FRAC    = COEF_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    MAC,
    POW,
    DONE
  } state_e;

  typedef enum logic {
    MODE_TAN = 1'b0,
    MODE_SIN = 1'b1
  } mode_e;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Nearest Q2.16 value of each series coefficient.
  localparam coef_t TAN_COEF [MAX_TERMS] = '{
    18'sd65536, 18'sd21845, 18'sd8738, 18'sd3537,
    18'sd1433,  18'sd581,   18'sd235,  18'sd95
  };

  localparam coef_t SIN_COEF [MAX_TERMS] = '{
    18'sd65536, -18'sd10923, 18'sd546, -18'sd13,
    18'sd0,     18'sd0,      18'sd0,   18'sd0
  };

endpackage

// File: rtl/trig_coef_rom.sv
// Combinational coefficient lookup: (mode, term index) -> signed Q2.16 coefficient.
module trig_coef_rom
  import trig_series_pkg::*;
(
  input  logic                     i_mode,
  input  logic [K_W-1:0]           i_k,
  output logic signed [COEF_W-1:0] o_coef
);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    o_coef = TAN_COEF[i_k];
    if (mode_e'(i_mode) == MODE_SIN) begin
      o_coef = SIN_COEF[i_k];
    end
  end

endmodule

// File: rtl/trig_series_engine.sv
// Iterative fixed-point Taylor evaluator of tan(x) or sin(x), x in [0,1), using one shared
// multiplier; a start/busy/ready slave beside the datapath.
module trig_series_engine
  import trig_series_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int N_TERMS = 8,
  parameter int GUARD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH:0]   y
);

  localparam int FW    = WIDTH + GUARD;
  localparam int ACC_W = FW + 2;
  localparam int PW    = FW + COEF_W + 1;
  localparam int RW    = ACC_W + 1 - GUARD;

  localparam logic [K_W-1:0]       K_LAST   = K_W'(N_TERMS - 1);
  localparam logic [WIDTH:0]       Y_MAX    = '1;
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W + 1)'(1 << (GUARD - 1));

  if (N_TERMS < 1 || N_TERMS > MAX_TERMS) begin : g_bad_terms
    $error("trig_series_engine: N_TERMS must be in 1..8");
  end
  if (GUARD < 1 || WIDTH < 1) begin : g_bad_width
    $error("trig_series_engine: WIDTH and GUARD must be at least 1");
  end

  state_e                   r_state;
  state_e                   w_state_next;
  mode_e                    r_mode;
  logic [FW-1:0]            r_p;
  logic [FW-1:0]            r_x2;
  logic signed [ACC_W-1:0]  r_acc;
  logic [K_W-1:0]           r_k;
  logic                     r_busy;
  logic                     r_ready;
  logic [WIDTH:0]           r_y;

  logic signed [COEF_W-1:0] w_coef;
  logic [FW-1:0]            w_b_src;
  logic [FW+B_FRAC-1:0]     w_b_wide;
  logic signed [COEF_W-1:0] w_mul_b;
  logic signed [PW-1:0]     w_mul_a_ext;
  logic signed [PW-1:0]     w_mul_b_ext;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_mac_term;
  logic [FW-1:0]            w_pow_term;
  logic signed [ACC_W:0]    w_acc_rnd;
  logic signed [RW-1:0]     w_rnd;
  logic [WIDTH:0]           w_y_sat;
  logic                     w_unused;

  trig_coef_rom u_coef_rom (
    .i_mode (r_mode),
    .i_k    (r_k),
    .o_coef (w_coef)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = SQR;
      SQR:     w_state_next = MAC;
      MAC:     w_state_next = POW;
      POW:     w_state_next = (r_k == K_LAST) ? DONE : MAC;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand A is always p; the coefficient port carries a coefficient (MAC) or a
  // top-aligned unsigned Q0.17 copy of p (SQR, p still holds x) or x2 (POW).
  assign w_b_src     = (r_state == SQR) ? r_p : r_x2;
  assign w_b_wide    = {w_b_src, {B_FRAC{1'b0}}};
  assign w_mul_b     = (r_state == MAC) ? w_coef
                                        : $signed({1'b0, w_b_wide[FW+B_FRAC-1 -: B_FRAC]});
  assign w_mul_a_ext = PW'($signed({1'b0, r_p}));
  assign w_mul_b_ext = PW'(w_mul_b);
  assign w_prod      = w_mul_a_ext * w_mul_b_ext;

  assign w_mac_term  = w_prod[COEF_FRAC +: ACC_W];
  assign w_pow_term  = w_prod[B_FRAC +: FW];

  // Round half up onto WIDTH fraction bits, then clamp into the unsigned Q1.WIDTH range.
  assign w_acc_rnd = {r_acc[ACC_W-1], r_acc} + RND_HALF;
  assign w_rnd     = w_acc_rnd[ACC_W:GUARD];

  always_comb begin
    w_y_sat = w_rnd[WIDTH:0];
    if (w_rnd[RW-1]) begin
      w_y_sat = '0;
    end else if (w_rnd[RW-2]) begin
      w_y_sat = Y_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= MODE_TAN;
      r_p     <= '0;
      r_x2    <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_y     <= '0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mode <= mode_e'(mode);
            r_p    <= {x, {GUARD{1'b0}}};
            r_acc  <= '0;
            r_k    <= '0;
            r_busy <= 1'b1;
          end
        end
        SQR: r_x2 <= w_pow_term;
        MAC: r_acc <= r_acc + w_mac_term;
        POW: begin
          r_p <= w_pow_term;
          r_k <= r_k + K_W'(1);
        end
        DONE: begin
          r_y     <= w_y_sat;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy  = r_busy;
  assign ready = r_ready;
  assign y     = r_y;

  assign w_unused = ^{w_prod[COEF_FRAC-1:0], w_prod[PW-1:COEF_FRAC+ACC_W],
                      w_b_wide[FW-1:0], w_acc_rnd[GUARD-1:0]};

endmodule
